// File: rtl/uart_rx_core.sv
// uart_rx_core: receive half of the UART. Oversamples the synchronised rx
// line on the 16x baud_clock tick and recovers 7/8-bit LSB-first frames
// with optional parity and one stop bit. Each byte is held for the host
// behind a ready/read handshake, together with its parity and framing
// status and a sticky overflow flag.
// Build option: define RX_MAJORITY_VOTE_EN to decide every bit by a
// 2-of-3 vote over three neighbouring samples instead of a single sample.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | line idle, waiting for a low sample on a tick
// START    | counting to the middle of the start bit to validate it
// DATA     | sampling data bits at samp_cnt=15, LSB first
// PARITY   | sampling the parity bit and checking it against the data
// STOP     | sampling the stop bit, then queueing the output load
// BRK_WAIT | stop bit was low (break or framing error): wait for rx high
module uart_rx_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  output logic [7:0] rx_byte,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_sync;
  logic [3:0]             samp_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_q;
  logic                   par_err_q;
  logic                   stop_q;
  logic                   load_q;
  logic                   samp_val;
  logic                   last_bit;

  assign rx_sync  = sync_q[SYNC_STAGES-1];
  assign last_bit = bit8 ? (bit_cnt == 3'd7) : (bit_cnt == 3'd6);

  // Bring the asynchronous rx line into the clk domain; idles high.
  always_ff @(posedge clk) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

`ifdef RX_MAJORITY_VOTE_EN
  // Keep the two previous tick samples; the live rx_sync is the third vote,
  // so decisions still happen on the same tick as the single-sample build.
  logic [1:0] vote_q;

  // Shift in one sample per baud tick.
  always_ff @(posedge clk) begin
    if (!reset_n)        vote_q <= 2'b11;
    else if (baud_clock) vote_q <= {vote_q[0], rx_sync};
  end

  assign samp_val = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_sync) |
                    (vote_q[0] & rx_sync);
`else
  assign samp_val = rx_sync;
`endif

  // Frame FSM on baud ticks, plus the one-clk-later output load and host read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      samp_cnt    <= 4'd0;
      bit_cnt     <= 3'd0;
      shift_q     <= 8'h00;
      par_err_q   <= 1'b0;
      stop_q      <= 1'b0;
      load_q      <= 1'b0;
      rx_byte     <= 8'h00;
      rx_ready    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      load_q <= 1'b0;

      if (baud_clock) begin
        case (state)
          IDLE: begin
            if (!rx_sync) begin
              state    <= START;
              samp_cnt <= 4'd0;
            end
          end
          START: begin
            if (samp_cnt == 4'd7) begin
              samp_cnt <= 4'd0;
              if (!samp_val) begin
                state     <= DATA;
                bit_cnt   <= 3'd0;
                shift_q   <= 8'h00;
                par_err_q <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else begin
              samp_cnt <= samp_cnt + 4'd1;
            end
          end
          DATA: begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == 4'd15) begin
              shift_q[bit_cnt] <= samp_val;
              bit_cnt          <= bit_cnt + 3'd1;
              if (last_bit) state <= parity_en ? PARITY : STOP;
            end
          end
          PARITY: begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == 4'd15) begin
              // shift_q[7] stays 0 in 7-bit mode, so a full XOR is correct.
              par_err_q <= ((^shift_q) ^ samp_val) != odd_n_even;
              state     <= STOP;
            end
          end
          STOP: begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == 4'd15) begin
              stop_q <= samp_val;
              load_q <= 1'b1;
              // A low stop bit may be a break; do not re-arm until rx is high.
              state  <= samp_val ? IDLE : BRK_WAIT;
            end
          end
          BRK_WAIT: begin
            if (rx_sync) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end

      if (load_q) begin
        if (!rx_ready || read_rx_byte) begin
          rx_byte     <= shift_q;
          parity_err  <= parity_en & par_err_q;
          framing_err <= ~stop_q;
          rx_ready    <= 1'b1;
          if (read_rx_byte) overflow <= 1'b0;
        end else begin
          overflow <= 1'b1;
        end
      end else if (read_rx_byte && rx_ready) begin
        rx_ready    <= 1'b0;
        parity_err  <= 1'b0;
        framing_err <= 1'b0;
        overflow    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with baud_clock high every clk
// (16 clks per bit). Frames are driven bit by bit; expected bytes and
// flags are hand-computed constants.
module tb_uart_rx_core;

  localparam int SYNC_STAGES = 2;

  logic       clk;
  logic       reset_n;
  logic       baud_clock;
  logic       rx;
  logic       bit8;
  logic       parity_en;
  logic       odd_n_even;
  logic       read_rx_byte;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int n_clk = 0;
  int rise_clk = -1;
  int start_clk = 0;
  int lat;
  logic prev_ready = 1'b0;

  uart_rx_core #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .baud_clock   (baud_clock),
    .rx           (rx),
    .bit8         (bit8),
    .parity_en    (parity_en),
    .odd_n_even   (odd_n_even),
    .read_rx_byte (read_rx_byte),
    .rx_byte      (rx_byte),
    .rx_ready     (rx_ready),
    .parity_err   (parity_err),
    .framing_err  (framing_err),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clk; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    n_clk++;
    if (rx_ready && !prev_ready && rise_clk < 0) rise_clk = n_clk;
    prev_ready = rx_ready;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  task automatic read_pulse();
    read_rx_byte = 1'b1;
    step();
    read_rx_byte = 1'b0;
  endtask

  // One bit period; with g set, rx is inverted for one clk at offset 7,
  // which lands on the samp_cnt=14 sample.
  task automatic send_bit(input logic v, input bit g);
    for (int c = 0; c < 16; c++) begin
      rx = (g && c == 7) ? ~v : v;
      step();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit has_par,
                            input logic par, input logic stop, input int glitch_bit);
    start_clk = n_clk;
    rise_clk  = -1;
    prev_ready = rx_ready;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i], glitch_bit == i);
    if (has_par) send_bit(par, 1'b0);
    send_bit(stop, 1'b0);
    rx = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; baud_clock = 1'b1; rx = 1'b1; bit8 = 1'b1;
    parity_en = 1'b0; odd_n_even = 1'b0; read_rx_byte = 1'b0;
    repeat (3) step();
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_framing_err", framing_err, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    reset_n = 1'b1;
    idle(20);

    // 8N1 0xA5 and ready latency (measured from the synchronised falling edge)
    send_frame(8'hA5, 8, 0, 1'b0, 1'b1, -1);
    check("a5_ready", rx_ready, 1'b1);
    check("a5_byte", rx_byte, 8'hA5);
    check("a5_parity_err", parity_err, 1'b0);
    check("a5_framing_err", framing_err, 1'b0);
    lat = rise_clk - start_clk - SYNC_STAGES;
    total++;
    assert (lat >= 151 && lat <= 155) else begin
      bad++;
      $error("FAIL a5_latency: observed=%0d expected=151..155", lat);
    end
    read_pulse();
    check("a5_read_clears", rx_ready, 1'b0);
    idle(20);

    // Short start glitch (4 ticks) is rejected
    rx = 1'b0;
    repeat (4) step();
    idle(40);
    check("glitch_no_ready", rx_ready, 1'b0);
    check("glitch_no_framing", framing_err, 1'b0);
    check("glitch_no_parity", parity_err, 1'b0);
    send_frame(8'h3C, 8, 0, 1'b0, 1'b1, -1);
    check("post_glitch_byte", rx_byte, 8'h3C);
    check("post_glitch_ready", rx_ready, 1'b1);
    read_pulse();
    idle(20);

    // 8E1: 0x3C has four ones, parity bit 1 is wrong for even parity
    parity_en = 1'b1; odd_n_even = 1'b0;
    send_frame(8'h3C, 8, 1, 1'b1, 1'b1, -1);
    check("8e1_byte", rx_byte, 8'h3C);
    check("8e1_parity_err", parity_err, 1'b1);
    read_pulse();
    check("8e1_read_clears_perr", parity_err, 1'b0);
    idle(20);
    // 8O1: same frame is correct for odd parity
    odd_n_even = 1'b1;
    send_frame(8'h3C, 8, 1, 1'b1, 1'b1, -1);
    check("8o1_byte", rx_byte, 8'h3C);
    check("8o1_parity_err", parity_err, 1'b0);
    read_pulse();
    idle(20);

    // 7N1
    parity_en = 1'b0; bit8 = 1'b0;
    send_frame(8'h55, 7, 0, 1'b0, 1'b1, -1);
    check("7n1_55_byte", rx_byte, 8'h55);
    check("7n1_55_framing", framing_err, 1'b0);
    read_pulse();
    idle(20);
    send_frame(8'h7F, 7, 0, 1'b0, 1'b0, -1);
    check("7n1_7f_byte", rx_byte, 8'h7F);
    check("7n1_7f_framing", framing_err, 1'b1);
    read_pulse();
    check("7n1_read_clears_ferr", framing_err, 1'b0);
    idle(40);
    send_frame(8'h2A, 7, 0, 1'b0, 1'b1, -1);
    check("7n1_after_ferr_byte", rx_byte, 8'h2A);
    check("7n1_after_ferr_framing", framing_err, 1'b0);
    check("7n1_after_ferr_ready", rx_ready, 1'b1);
    read_pulse();
    idle(20);

    // Break: rx held low gives 0x00 with framing error, no re-trigger while low
    bit8 = 1'b1;
    rx = 1'b0;
    repeat (200) step();
    check("break_ready", rx_ready, 1'b1);
    check("break_byte", rx_byte, 8'h00);
    check("break_framing", framing_err, 1'b1);
    read_pulse();
    rx = 1'b0;
    repeat (100) step();
    check("break_no_rearm_low", rx_ready, 1'b0);
    idle(40);
    check("break_idle_ready", rx_ready, 1'b0);

    // Overflow: second byte lost while first is unread
    send_frame(8'h11, 8, 0, 1'b0, 1'b1, -1);
    idle(20);
    send_frame(8'h22, 8, 0, 1'b0, 1'b1, -1);
    check("ovf_byte_kept", rx_byte, 8'h11);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_ready", rx_ready, 1'b1);
    read_pulse();
    check("ovf_read_ready", rx_ready, 1'b0);
    check("ovf_read_clears", overflow, 1'b0);
    idle(20);

    // Reset in the middle of data bit 3 while a byte is held
    send_frame(8'h5A, 8, 0, 1'b0, 1'b1, -1);
    idle(20);
    rx = 1'b0;
    repeat (16) step();
    repeat (48) step();
    rx = 1'b1;
    repeat (8) step();
    reset_n = 1'b0;
    step();
    check("midrst_rx_byte", rx_byte, 8'h00);
    check("midrst_rx_ready", rx_ready, 1'b0);
    check("midrst_parity_err", parity_err, 1'b0);
    check("midrst_framing_err", framing_err, 1'b0);
    check("midrst_overflow", overflow, 1'b0);
    reset_n = 1'b1;
    idle(8 + 64 + 16 + 40);
    check("midrst_no_garbage", rx_ready, 1'b0);
    send_frame(8'h81, 8, 0, 1'b0, 1'b1, -1);
    check("after_rst_byte", rx_byte, 8'h81);
    check("after_rst_ready", rx_ready, 1'b1);
    read_pulse();
    idle(20);

`ifdef RX_MAJORITY_VOTE_EN
    // One-clk glitch on the samp_cnt=14 sample of bit 2 is outvoted
    send_frame(8'hC3, 8, 0, 1'b0, 1'b1, 2);
    check("vote_glitch_byte", rx_byte, 8'hC3);
    read_pulse();
    idle(20);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
